// File: rtl/msrh_brtag_allocator_pkg.sv
// Shared defaults, tag/mask types and the bit-count helper for the brtag allocator.
package msrh_brtag_allocator_pkg;

    localparam int DEF_DISP_SIZE  = 4;
    localparam int DEF_BRTAG_SIZE = 16;
    localparam int DEF_TAG_W      = $clog2(DEF_BRTAG_SIZE);

    typedef logic [DEF_TAG_W-1:0]      brtag_t;
    typedef logic [DEF_BRTAG_SIZE-1:0] brmask_t;

    // Population count over a zero-extended vector of up to 64 bits.
    function automatic int unsigned bit_cnt(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/msrh_brtag_allocator_if.sv
// Dispatch, commit, branch-update and status bundle between the allocator and its neighbours.
interface msrh_brtag_allocator_if
    import msrh_brtag_allocator_pkg::*;
#(
    parameter int DISP_SIZE  = DEF_DISP_SIZE,
    parameter int BRTAG_SIZE = DEF_BRTAG_SIZE
);
    localparam int TAG_W = $clog2(BRTAG_SIZE);

    logic [DISP_SIZE-1:0]            i_disp_valid;
    logic [DISP_SIZE-1:0]            i_disp_is_br;
    logic                            i_disp_fire;
    logic                            o_disp_ready;
    logic [DISP_SIZE*TAG_W-1:0]      o_disp_brtag;
    logic [DISP_SIZE*BRTAG_SIZE-1:0] o_disp_br_mask;

    logic                            i_cmt_commit;
    logic [DISP_SIZE-1:0]            i_cmt_is_br_inst;
    logic [DISP_SIZE*TAG_W-1:0]      i_cmt_brtag;
    logic [BRTAG_SIZE-1:0]           o_cmt_clear_mask;

    logic                            i_br_upd_update;
    logic                            i_br_upd_mispredict;
    logic                            i_br_upd_dead;
    logic [TAG_W-1:0]                i_br_upd_brtag;
    logic [BRTAG_SIZE-1:0]           i_br_upd_br_mask;

    logic                            i_flush;
    logic [BRTAG_SIZE-1:0]           o_alloc_vec;
    logic [TAG_W:0]                  o_free_cnt;

    modport slave (
        input  i_disp_valid, i_disp_is_br, i_disp_fire,
        output o_disp_ready, o_disp_brtag, o_disp_br_mask,
        input  i_cmt_commit, i_cmt_is_br_inst, i_cmt_brtag,
        output o_cmt_clear_mask,
        input  i_br_upd_update, i_br_upd_mispredict, i_br_upd_dead,
        input  i_br_upd_brtag, i_br_upd_br_mask,
        input  i_flush,
        output o_alloc_vec, o_free_cnt
    );

    modport master (
        output i_disp_valid, i_disp_is_br, i_disp_fire,
        input  o_disp_ready, o_disp_brtag, o_disp_br_mask,
        output i_cmt_commit, i_cmt_is_br_inst, i_cmt_brtag,
        input  o_cmt_clear_mask,
        output i_br_upd_update, i_br_upd_mispredict, i_br_upd_dead,
        output i_br_upd_brtag, i_br_upd_br_mask,
        output i_flush,
        input  o_alloc_vec, o_free_cnt
    );

endinterface

// File: rtl/msrh_brtag_allocator_pick.sv
// Picks up to PICK_N lowest-index free (0) bits of a vector, one-hot per pick.
module msrh_multi_pick_lowest #(
    parameter int PICK_N = 4,
    parameter int VEC_W  = 16
) (
    input  logic [VEC_W-1:0]             used_i,
    output logic [PICK_N-1:0][VEC_W-1:0] pick_oh_o,
    output logic [PICK_N-1:0]            pick_valid_o
);

    // Peel off the lowest free bit PICK_N times.
    always_comb begin
        logic [VEC_W-1:0] avail;
        avail        = ~used_i;
        pick_oh_o    = '0;
        pick_valid_o = '0;
        for (int k = 0; k < PICK_N; k++) begin
            pick_valid_o[k] = |avail;
            pick_oh_o[k]    = avail & (~avail + VEC_W'(1));
            avail           = avail & ~pick_oh_o[k];
        end
    end

endmodule

// File: rtl/msrh_brtag_allocator.sv
// Branch-tag pool: hands out tags to dispatching branches, recycles them on
// commit, mispredict and flush, and builds per-lane dependency masks.
module msrh_brtag_allocator
    import msrh_brtag_allocator_pkg::*;
#(
    parameter int DISP_SIZE  = DEF_DISP_SIZE,
    parameter int BRTAG_SIZE = DEF_BRTAG_SIZE
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    msrh_brtag_allocator_if.slave  bus
);

    localparam int TAG_W = $clog2(BRTAG_SIZE);

    logic [BRTAG_SIZE-1:0]                alloc_q, alloc_d;
    logic [TAG_W:0]                       free_cnt_q, free_cnt_d;
    logic [DISP_SIZE-1:0]                 br_lane;
    logic [TAG_W:0]                       need;
    logic                                 ready;
    logic [DISP_SIZE-1:0][BRTAG_SIZE-1:0] pick_oh;
    logic [DISP_SIZE-1:0]                 pick_valid;
    logic [DISP_SIZE-1:0][BRTAG_SIZE-1:0] lane_oh;
    logic [DISP_SIZE-1:0][BRTAG_SIZE-1:0] lane_mask;
    logic [DISP_SIZE-1:0][TAG_W-1:0]      lane_tag;
    logic [BRTAG_SIZE-1:0]                grant_all;
    logic [BRTAG_SIZE-1:0]                alloc_set, commit_set, kill_set;
    logic                                 mp, kill, fire_eff;

    msrh_multi_pick_lowest #(
        .PICK_N (DISP_SIZE),
        .VEC_W  (BRTAG_SIZE)
    ) u_pick (
        .used_i       (alloc_q),
        .pick_oh_o    (pick_oh),
        .pick_valid_o (pick_valid)
    );

    assign br_lane = bus.i_disp_valid & bus.i_disp_is_br;
    assign need    = (TAG_W+1)'(bit_cnt(64'(br_lane)));
    assign ready   = free_cnt_q >= need;

    // The k-th branch lane takes the k-th pick; masks accumulate older same-group tags.
    always_comb begin
        logic [BRTAG_SIZE-1:0] acc;
        int rank;
        acc       = alloc_q;
        rank      = 0;
        lane_oh   = '0;
        lane_mask = '0;
        grant_all = '0;
        for (int l = 0; l < DISP_SIZE; l++) begin
            lane_mask[l] = acc;
            if (br_lane[l]) begin
                for (int k = 0; k < DISP_SIZE; k++) begin
                    if (k == rank && pick_valid[k]) lane_oh[l] = pick_oh[k];
                end
                acc       = acc | lane_oh[l];
                grant_all = grant_all | lane_oh[l];
                rank++;
            end
        end
    end

    // One-hot to index per lane; non-branch lanes read as tag 0.
    always_comb begin
        lane_tag = '0;
        for (int l = 0; l < DISP_SIZE; l++) begin
            for (int t = 0; t < BRTAG_SIZE; t++) begin
                if (lane_oh[l][t]) lane_tag[l] = TAG_W'(t);
            end
        end
    end

    // Tags retired by branches committing this cycle.
    always_comb begin
        commit_set = '0;
        for (int l = 0; l < DISP_SIZE; l++) begin
            if (bus.i_cmt_commit && bus.i_cmt_is_br_inst[l])
                commit_set[bus.i_cmt_brtag[l*TAG_W +: TAG_W]] = 1'b1;
        end
    end

    assign mp       = bus.i_br_upd_update & bus.i_br_upd_mispredict & ~bus.i_br_upd_dead;
    assign kill     = mp | bus.i_flush;
    assign fire_eff = bus.i_disp_fire & ready & ~kill;
    assign alloc_set = fire_eff ? grant_all : '0;
    // The resolving branch and everything older survive; younger live tags are reclaimed.
    assign kill_set = mp ? (alloc_q & ~bus.i_br_upd_br_mask & ~(BRTAG_SIZE'(1) << bus.i_br_upd_brtag))
                         : '0;

    // Next pool state; flush overrides every other update.
    always_comb begin
        if (bus.i_flush) alloc_d = '0;
        else             alloc_d = (alloc_q | alloc_set) & ~commit_set & ~kill_set;
        free_cnt_d = (TAG_W+1)'(BRTAG_SIZE - int'(bit_cnt(64'(alloc_d))));
    end

    // Pool registers, count recomputed from the vector rather than tracked incrementally.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            alloc_q    <= '0;
            free_cnt_q <= (TAG_W+1)'(BRTAG_SIZE);
        end else begin
            alloc_q    <= alloc_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign bus.o_disp_ready     = ready;
    assign bus.o_disp_brtag     = lane_tag;
    assign bus.o_disp_br_mask   = lane_mask;
    assign bus.o_cmt_clear_mask = commit_set;
    assign bus.o_alloc_vec      = alloc_q;
    assign bus.o_free_cnt       = free_cnt_q;

    // Protocol checks on the neighbouring stages.
    always @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(bus.i_disp_fire && !ready));
            assert ((commit_set & ~alloc_q) == '0);
            assert ((commit_set & kill_set) == '0);
        end
    end

endmodule

// File: tb/tb_msrh_brtag_allocator.sv
module tb_msrh_brtag_allocator;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    msrh_brtag_allocator_if #(.DISP_SIZE(4), .BRTAG_SIZE(16)) bus ();

    msrh_brtag_allocator #(.DISP_SIZE(4), .BRTAG_SIZE(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.i_disp_valid        = '0;
        bus.i_disp_is_br        = '0;
        bus.i_disp_fire         = 1'b0;
        bus.i_cmt_commit        = 1'b0;
        bus.i_cmt_is_br_inst    = '0;
        bus.i_cmt_brtag         = '0;
        bus.i_br_upd_update     = 1'b0;
        bus.i_br_upd_mispredict = 1'b0;
        bus.i_br_upd_dead       = 1'b0;
        bus.i_br_upd_brtag      = '0;
        bus.i_br_upd_br_mask    = '0;
        bus.i_flush             = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fires all-branch groups until n tags are taken, then idles at the next negedge.
    task automatic alloc_n(input int n);
        int left;
        int k;
        left = n;
        while (left > 0) begin
            k = (left > 4) ? 4 : left;
            @(negedge clk);
            idle();
            bus.i_disp_valid = 4'((1 << k) - 1);
            bus.i_disp_is_br = 4'((1 << k) - 1);
            bus.i_disp_fire  = 1'b1;
            left -= k;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (bus.o_alloc_vec !== 16'h0000) $display("FAIL reset_alloc: got %h want 0000", bus.o_alloc_vec); else passed++;
        total++; if (bus.o_free_cnt !== 5'd16) $display("FAIL reset_free: got %0d want 16", bus.o_free_cnt); else passed++;
        total++; if (bus.o_disp_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.o_disp_ready); else passed++;
        total++; if (bus.o_cmt_clear_mask !== 16'h0000) $display("FAIL reset_clear: got %h want 0000", bus.o_cmt_clear_mask); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_alloc();
        do_reset();
        @(negedge clk);
        bus.i_disp_valid = 4'b1111;
        bus.i_disp_is_br = 4'b1011;
        bus.i_disp_fire  = 1'b1;
        #1;
        total++; if (bus.o_disp_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", bus.o_disp_ready); else passed++;
        total++; if (bus.o_disp_brtag[3:0] !== 4'd0) $display("FAIL basic_tag_l0: got %0d want 0", bus.o_disp_brtag[3:0]); else passed++;
        total++; if (bus.o_disp_brtag[7:4] !== 4'd1) $display("FAIL basic_tag_l1: got %0d want 1", bus.o_disp_brtag[7:4]); else passed++;
        total++; if (bus.o_disp_brtag[15:12] !== 4'd2) $display("FAIL basic_tag_l3: got %0d want 2", bus.o_disp_brtag[15:12]); else passed++;
        total++; if (bus.o_disp_br_mask[15:0] !== 16'h0000) $display("FAIL basic_mask_l0: got %h want 0000", bus.o_disp_br_mask[15:0]); else passed++;
        total++; if (bus.o_disp_br_mask[31:16] !== 16'h0001) $display("FAIL basic_mask_l1: got %h want 0001", bus.o_disp_br_mask[31:16]); else passed++;
        total++; if (bus.o_disp_br_mask[63:48] !== 16'h0003) $display("FAIL basic_mask_l3: got %h want 0003", bus.o_disp_br_mask[63:48]); else passed++;
        @(negedge clk);
        idle();
        total++; if (bus.o_alloc_vec !== 16'h0007) $display("FAIL basic_alloc: got %h want 0007", bus.o_alloc_vec); else passed++;
        total++; if (bus.o_free_cnt !== 5'd13) $display("FAIL basic_free: got %0d want 13", bus.o_free_cnt); else passed++;
    endtask

    task automatic test_full_pool();
        do_reset();
        alloc_n(15);
        total++; if (bus.o_alloc_vec !== 16'h7fff) $display("FAIL full_alloc: got %h want 7fff", bus.o_alloc_vec); else passed++;
        total++; if (bus.o_free_cnt !== 5'd1) $display("FAIL full_free: got %0d want 1", bus.o_free_cnt); else passed++;
        bus.i_disp_valid = 4'b0011;
        bus.i_disp_is_br = 4'b0011;
        #1;
        total++; if (bus.o_disp_ready !== 1'b0) $display("FAIL full_two_br_ready: got %b want 0", bus.o_disp_ready); else passed++;
        @(negedge clk);
        total++; if (bus.o_alloc_vec !== 16'h7fff) $display("FAIL full_alloc_hold: got %h want 7fff", bus.o_alloc_vec); else passed++;
        bus.i_disp_valid = 4'b1111;
        bus.i_disp_is_br = 4'b0000;
        #1;
        total++; if (bus.o_disp_ready !== 1'b1) $display("FAIL full_no_br_ready: got %b want 1", bus.o_disp_ready); else passed++;
        bus.i_disp_valid = 4'b0001;
        bus.i_disp_is_br = 4'b0001;
        #1;
        total++; if (bus.o_disp_ready !== 1'b1) $display("FAIL full_one_br_ready: got %b want 1", bus.o_disp_ready); else passed++;
        total++; if (bus.o_disp_brtag[3:0] !== 4'd15) $display("FAIL full_last_tag: got %0d want 15", bus.o_disp_brtag[3:0]); else passed++;
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_n(6);
        total++; if (bus.o_alloc_vec !== 16'h003f) $display("FAIL mp_pre_alloc: got %h want 003f", bus.o_alloc_vec); else passed++;
        bus.i_br_upd_update     = 1'b1;
        bus.i_br_upd_mispredict = 1'b1;
        bus.i_br_upd_brtag      = 4'd2;
        bus.i_br_upd_br_mask    = 16'h0003;
        bus.i_disp_valid        = 4'b0001;
        bus.i_disp_is_br        = 4'b0001;
        bus.i_disp_fire         = 1'b1;
        @(negedge clk);
        idle();
        total++; if (bus.o_alloc_vec !== 16'h0007) $display("FAIL mp_alloc: got %h want 0007", bus.o_alloc_vec); else passed++;
        total++; if (bus.o_free_cnt !== 5'd13) $display("FAIL mp_free: got %0d want 13", bus.o_free_cnt); else passed++;
        bus.i_disp_valid = 4'b0001;
        bus.i_disp_is_br = 4'b0001;
        #1;
        total++; if (bus.o_disp_brtag[3:0] !== 4'd3) $display("FAIL mp_recycled_tag: got %0d want 3", bus.o_disp_brtag[3:0]); else passed++;
        idle();
        bus.i_br_upd_update     = 1'b1;
        bus.i_br_upd_mispredict = 1'b1;
        bus.i_br_upd_dead       = 1'b1;
        bus.i_br_upd_brtag      = 4'd0;
        bus.i_br_upd_br_mask    = 16'h0000;
        @(negedge clk);
        idle();
        total++; if (bus.o_alloc_vec !== 16'h0007) $display("FAIL mp_dead_ignored: got %h want 0007", bus.o_alloc_vec); else passed++;
    endtask

    task automatic test_commit();
        do_reset();
        alloc_n(5);
        total++; if (bus.o_alloc_vec !== 16'h001f) $display("FAIL cmt_pre_alloc: got %h want 001f", bus.o_alloc_vec); else passed++;
        bus.i_cmt_commit     = 1'b1;
        bus.i_cmt_is_br_inst = 4'b0010;
        bus.i_cmt_brtag      = 16'h0040;
        bus.i_disp_valid     = 4'b0001;
        bus.i_disp_is_br     = 4'b0001;
        #1;
        total++; if (bus.o_cmt_clear_mask !== 16'h0010) $display("FAIL cmt_clear: got %h want 0010", bus.o_cmt_clear_mask); else passed++;
        total++; if (bus.o_disp_brtag[3:0] !== 4'd5) $display("FAIL cmt_no_bypass: got %0d want 5", bus.o_disp_brtag[3:0]); else passed++;
        @(negedge clk);
        bus.i_cmt_commit     = 1'b0;
        bus.i_cmt_is_br_inst = '0;
        bus.i_cmt_brtag      = '0;
        #1;
        total++; if (bus.o_disp_brtag[3:0] !== 4'd4) $display("FAIL cmt_recycled_tag: got %0d want 4", bus.o_disp_brtag[3:0]); else passed++;
        total++; if (bus.o_alloc_vec !== 16'h000f) $display("FAIL cmt_alloc: got %h want 000f", bus.o_alloc_vec); else passed++;
        total++; if (bus.o_free_cnt !== 5'd12) $display("FAIL cmt_free: got %0d want 12", bus.o_free_cnt); else passed++;
        total++; if (bus.o_cmt_clear_mask !== 16'h0000) $display("FAIL cmt_clear_idle: got %h want 0000", bus.o_cmt_clear_mask); else passed++;
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(10);
        total++; if (bus.o_alloc_vec !== 16'h03ff) $display("FAIL flush_pre_alloc: got %h want 03ff", bus.o_alloc_vec); else passed++;
        bus.i_flush          = 1'b1;
        bus.i_cmt_commit     = 1'b1;
        bus.i_cmt_is_br_inst = 4'b0001;
        bus.i_cmt_brtag      = 16'h0003;
        bus.i_disp_valid     = 4'b0001;
        bus.i_disp_is_br     = 4'b0001;
        bus.i_disp_fire      = 1'b1;
        #1;
        total++; if (bus.o_cmt_clear_mask !== 16'h0008) $display("FAIL flush_clear: got %h want 0008", bus.o_cmt_clear_mask); else passed++;
        @(negedge clk);
        idle();
        total++; if (bus.o_alloc_vec !== 16'h0000) $display("FAIL flush_alloc: got %h want 0000", bus.o_alloc_vec); else passed++;
        total++; if (bus.o_free_cnt !== 5'd16) $display("FAIL flush_free: got %0d want 16", bus.o_free_cnt); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_n(8);
        total++; if (bus.o_alloc_vec !== 16'h00ff) $display("FAIL arst_pre_alloc: got %h want 00ff", bus.o_alloc_vec); else passed++;
        total++; if (bus.o_free_cnt !== 5'd8) $display("FAIL arst_pre_free: got %0d want 8", bus.o_free_cnt); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.o_alloc_vec !== 16'h0000) $display("FAIL arst_alloc: got %h want 0000", bus.o_alloc_vec); else passed++;
        total++; if (bus.o_free_cnt !== 5'd16) $display("FAIL arst_free: got %0d want 16", bus.o_free_cnt); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_basic_alloc();
        test_full_pool();
        test_mispredict();
        test_commit();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
